// File: rtl/simd_mem_pkg.sv
// Shared definitions for the SIMD memory-side blocks: default sizes and the
// vector load/store sequencer state encoding.
package simd_mem_pkg;

    localparam int LANES         = 4;
    localparam int DATA_W        = 32;
    localparam int LSU_ADDR_STEP = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LDRAIN,
        STORE,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/vector_lsu.sv
// Vector load/store sequencer: splits one whole-vector request into one scalar
// data_memory access per lane (one lane per cycle), reassembles load data and
// returns the result over a valid/ready response port. One request in flight.
module vector_lsu
    import simd_mem_pkg::*;
#(
    parameter int dataSize       = DATA_W,
    parameter int addressingSize = 32,
    parameter int lanes          = LANES,
    parameter int ADDR_STEP      = LSU_ADDR_STEP
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [addressingSize-1:0]          req_addr,
    input  logic [lanes-1:0]                   req_mask,
    input  logic [lanes-1:0][dataSize-1:0]     req_wdata,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [lanes-1:0][dataSize-1:0]     resp_rdata,
    output logic                               mem_write_enable,
    output logic [addressingSize-1:0]          mem_addr,
    output logic [dataSize-1:0]                mem_wdata,
    input  logic [dataSize-1:0]                mem_rdata
);

    // Counter reaches `lanes` in LDRAIN, hence the extra bit of range.
    localparam int KW = $clog2(lanes + 1);
    localparam logic [KW-1:0] LAST_LANE = KW'(lanes - 1);

    lsu_state_t                          r_state;
    lsu_state_t                          w_state_next;
    logic [KW-1:0]                       r_k;
    logic [addressingSize-1:0]           r_base;
    logic [lanes-1:0]                    r_mask;
    logic [lanes-1:0][dataSize-1:0]      r_wdata;
    logic [lanes-1:0][dataSize-1:0]      r_rdata;

    logic [addressingSize-1:0]           w_lane_addr;
    logic [dataSize-1:0]                 w_lane_wdata;
    logic                                w_lane_mask;

    // Lane address wraps silently at addressingSize bits.
    assign w_lane_addr = r_base + addressingSize'(r_k) * addressingSize'(ADDR_STEP);
    assign resp_rdata  = r_rdata;

    // Select the latched store data and enable of the current lane.
    always_comb begin
        w_lane_wdata = '0;
        w_lane_mask  = 1'b0;
        for (int unsigned i = 0; i < lanes; i++) begin
            if (KW'(i) == r_k) begin
                w_lane_wdata = r_wdata[i];
                w_lane_mask  = r_mask[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake / memory-port outputs.
    always_comb begin
        w_state_next     = r_state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = req_write ? STORE : LOAD;
                end
            end
            STORE: begin
                mem_addr         = w_lane_addr;
                mem_wdata        = w_lane_wdata;
                mem_write_enable = w_lane_mask;
                if (r_k == LAST_LANE) begin
                    w_state_next = RESP;
                end
            end
            LOAD: begin
                mem_addr = w_lane_addr;
                if (r_k == LAST_LANE) begin
                    w_state_next = LDRAIN;
                end
            end
            LDRAIN: begin
                w_state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch, lane counter and load-data reassembly.
    // Read data returns one edge after issue, so lane k-1 is captured while
    // lane k is issued; LDRAIN (k == lanes) picks up the final lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_base  <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_k <= '0;
                    if (req_valid) begin
                        r_base  <= req_addr;
                        r_mask  <= req_mask;
                        r_wdata <= req_wdata;
                    end
                end
                STORE: begin
                    r_k <= r_k + 1'b1;
                end
                LOAD, LDRAIN: begin
                    if (r_state == LOAD) begin
                        r_k <= r_k + 1'b1;
                    end
                    for (int unsigned i = 0; i < lanes; i++) begin
                        if (KW'(i + 1) == r_k) begin
                            r_rdata[i] <= r_mask[i] ? mem_rdata : '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: table of vector requests with hand-computed
// results, plus back-pressure and reset-mid-store sequences. A behavioural
// data_memory (registered read, logged writes) sits on the memory port.
module tb_vector_lsu;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [3:0]           req_mask;
    logic [3:0][31:0]     req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [3:0][31:0]     resp_rdata;
    logic                 mem_write_enable;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    vector_lsu #(
        .dataSize(32),
        .addressingSize(32),
        .lanes(4),
        .ADDR_STEP(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_mask(req_mask),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: one-edge read latency, writes logged in order.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];

    always @(posedge clk) begin
        logic [31:0] rd;
        rd = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_write_enable) begin
            mem[mem_addr] = mem_wdata;
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
        mem_rdata <= rd;
    end

    typedef struct {
        logic             wr;
        logic [31:0]      addr;
        logic [3:0]       mask;
        logic [3:0][31:0] wdata;
        logic [3:0][31:0] exp_rdata;
        int               exp_lat;
        int               exp_nwr;
        logic [3:0][31:0] exp_waddr;
        logic [3:0][31:0] exp_wdat;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [3:0][31:0] v4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        logic [3:0][31:0] r;
        r[0] = l0; r[1] = l1; r[2] = l2; r[3] = l3;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        int   cyc;
        int   base;
        bit   got;
        bit   busy_bad;
        v = vecs[n];
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", n), 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_mask  = v.mask;
        req_wdata = v.wdata;
        base = wlog_a.size();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        got = 1'b0;
        busy_bad = 1'b0;
        while (!got && cyc <= 50) begin
            if (resp_valid) begin
                got = 1'b1;
            end else begin
                if (req_ready) busy_bad = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d_latency", n), got ? 128'(cyc) : 128'hDEAD, 128'(v.exp_lat));
        chk($sformatf("v%0d_busy_ready", n), 128'(busy_bad | req_ready), 128'(0));
        chk($sformatf("v%0d_rdata", n), 128'(resp_rdata), 128'(v.exp_rdata));
        @(negedge clk);
        chk($sformatf("v%0d_after_resp", n), 128'({resp_valid, req_ready}), 128'(2'b01));
        chk($sformatf("v%0d_nwrites", n), 128'(wlog_a.size() - base), 128'(v.exp_nwr));
        for (int i = 0; i < v.exp_nwr; i++) begin
            if (base + i < wlog_a.size()) begin
                chk($sformatf("v%0d_waddr%0d", n, i), 128'(wlog_a[base + i]), 128'(v.exp_waddr[i]));
                chk($sformatf("v%0d_wdata%0d", n, i), 128'(wlog_d[base + i]), 128'(v.exp_wdat[i]));
            end
        end
    endtask

    initial begin
        logic [3:0][31:0] q1234;
        logic [3:0][31:0] held;
        logic [3:0][31:0] bp_exp;
        int   cyc;
        int   base;
        bit   got;
        bit   bp_bad;

        q1234 = v4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        vecs[0]  = '{1'b1, 32'h40, 4'b1111, q1234, '0, 5, 4,
                     v4(32'h40, 32'h50, 32'h60, 32'h70), q1234};
        vecs[1]  = '{1'b0, 32'h40, 4'b1111, '0, q1234, 6, 0, '0, '0};
        vecs[2]  = '{1'b1, 32'h100, 4'b1111, v4(32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA),
                     q1234, 5, 4, v4(32'h100, 32'h110, 32'h120, 32'h130),
                     v4(32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA)};
        vecs[3]  = '{1'b1, 32'h100, 4'b0101, v4(32'hDEAD0000, 32'h0BAD0001, 32'hC0DE0002, 32'h0BAD0003),
                     q1234, 5, 2, v4(32'h100, 32'h120, 32'h0, 32'h0),
                     v4(32'hDEAD0000, 32'hC0DE0002, 32'h0, 32'h0)};
        vecs[4]  = '{1'b0, 32'h100, 4'b1111, '0,
                     v4(32'hDEAD0000, 32'hAAAAAAAA, 32'hC0DE0002, 32'hAAAAAAAA), 6, 0, '0, '0};
        vecs[5]  = '{1'b0, 32'h40, 4'b0010, '0, v4(32'h0, 32'h22222222, 32'h0, 32'h0), 6, 0, '0, '0};
        vecs[6]  = '{1'b1, 32'h40, 4'b0000, v4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF),
                     v4(32'h0, 32'h22222222, 32'h0, 32'h0), 5, 0, '0, '0};
        vecs[7]  = '{1'b0, 32'h40, 4'b0000, '0, '0, 6, 0, '0, '0};
        vecs[8]  = '{1'b0, 32'h40, 4'b1111, '0, q1234, 6, 0, '0, '0};
        vecs[9]  = '{1'b1, 32'hFFFFFFF0, 4'b1111, v4(32'h5, 32'h6, 32'h7, 32'h8), q1234, 5, 4,
                     v4(32'hFFFFFFF0, 32'h0, 32'h10, 32'h20), v4(32'h5, 32'h6, 32'h7, 32'h8)};
        vecs[10] = '{1'b0, 32'h0, 4'b0001, '0, v4(32'h6, 32'h0, 32'h0, 32'h0), 6, 0, '0, '0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_mask   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_handshake", 128'({req_ready, resp_valid}), 128'(2'b10));
        chk("reset_rdata", 128'(resp_rdata), 128'(0));
        chk("reset_mem", 128'({mem_write_enable, mem_addr, mem_wdata}), 128'(0));
        rst = 1'b0;

        for (int n = 0; n < 11; n++) begin
            run_vec(n);
        end

        // Back-pressure: response held for many cycles with resp_ready low.
        bp_exp = v4(32'hDEAD0000, 32'hAAAAAAAA, 32'hC0DE0002, 32'hAAAAAAAA);
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_mask = 4'b1111; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 50) begin
            if (resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("bp_latency", got ? 128'(cyc) : 128'hDEAD, 128'(6));
        held = resp_rdata;
        chk("bp_rdata", 128'(held), 128'(bp_exp));
        bp_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_rdata !== bp_exp || req_ready !== 1'b0 || resp_valid !== 1'b1 ||
                mem_write_enable !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
                bp_bad = 1'b1;
        end
        chk("bp_hold_stable", 128'(bp_bad), 128'(0));
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 128'({resp_valid, req_ready}), 128'(2'b01));

        // Reset during lane 1 of a store: lanes 2-3 must never be written.
        base = wlog_a.size();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_mask = 4'b1111;
        req_wdata = v4(32'h1, 32'h2, 32'h3, 32'h4);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_lane0", 128'({mem_write_enable, mem_addr, mem_wdata}), 128'({1'b1, 32'h200, 32'h1}));
        @(negedge clk);
        chk("rst_lane1", 128'({mem_write_enable, mem_addr, mem_wdata}), 128'({1'b1, 32'h210, 32'h2}));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_handshake", 128'({req_ready, resp_valid}), 128'(2'b10));
        chk("rst_mid_rdata", 128'(resp_rdata), 128'(0));
        chk("rst_mid_mem", 128'({mem_write_enable, mem_addr, mem_wdata}), 128'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_nwrites", 128'(wlog_a.size() - base), 128'(2));
        chk("rst_mid_lane2_unwritten", 128'(mem.exists(32'h220)), 128'(0));
        chk("rst_mid_lane3_unwritten", 128'(mem.exists(32'h230)), 128'(0));
        chk("rst_mid_idle", 128'({req_ready, resp_valid, mem_write_enable}), 128'(3'b100));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store sequencer between the SIMD pipeline's memory stage and `data_memory` instantiated with `vecSize = 1`. It accepts one whole-vector load or store per request and splits it into one scalar word access per lane, one lane per cycle. Load results are reassembled into a vector, then returned over a valid/ready response port. One request is in flight at a time.

## Interface
Parameters:
- `dataSize`, 32, lane width in bits; multiple of 8.
- `addressingSize`, 32, address width.
- `lanes`, 4, vector lanes per request; ≥ 2.
- `ADDR_STEP`, 16, `mem_addr` increment between lanes. `data_memory` takes `DataAdr[addressingSize-1:2]` as its byte base, so step 16 gives consecutive 4-byte words.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  `addressingSize`  base address of lane 0.
- `req_mask`  in  `lanes`  per-lane enable.
- `req_wdata`  in  `[lanes][dataSize]`  store data.
- `resp_valid`  out  1  request complete.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  `[lanes][dataSize]`  load result.
- `mem_write_enable`  out  1  drives `data_memory.write_enable`.
- `mem_addr`  out  `addressingSize`  drives `DataAdr`.
- `mem_wdata`  out  `dataSize`  drives `toWrite_data[0]`.
- `mem_rdata`  in  `dataSize`  from `read_data[0]`.

## Operation
- States: IDLE, LOAD, LDRAIN, STORE, RESP.
- **Request capture.** In IDLE, `req_ready = 1`. A request is accepted when `req_valid & req_ready` at a rising edge. The block latches `req_addr`, `req_mask`, `req_wdata` and `req_write`, and clears the lane counter `k`.
- **Lane address.** Lane `k` uses `mem_addr = base + k*ADDR_STEP`, truncated to `addressingSize`. Wrap-around is silent.
- **STORE.**
  - Each cycle, `mem_addr` = lane `k` address and `mem_wdata` = `wdata[k]`.
  - `mem_write_enable = mask[k]`.
  - A masked lane still consumes its cycle, so latency is fixed.
  - After lane `lanes-1`, go to RESP.
- **LOAD.**
  - Each cycle, lane `k` is issued with `mem_write_enable = 0`.
  - In the same cycle, lane `k-1` is captured from `mem_rdata` (memory read latency is 1 edge).
  - After issuing lane `lanes-1`, go to LDRAIN, which captures the last lane, then go to RESP.
  - Masked lanes are captured as 0.
- **RESP.**
  - `resp_valid = 1`; `resp_rdata` is held stable until `resp_valid & resp_ready`, then go to IDLE.
  - Store responses leave `resp_rdata` unchanged.
- **IDLE outputs.** `mem_write_enable = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **`mem_*` generation.** The `mem_*` outputs are combinational from state, `k` and the latched request.

## Timing
- **Reset.** On `rst` the block goes to IDLE with `k = 0`.
  - `req_ready = 1`, `resp_valid = 0`, `resp_rdata = 0`.
  - `mem_write_enable = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **Reset mid-operation.** Reset aborts the request. No further memory write occurs after the reset edge; lanes already written stay written.
- **Latency.** Accept edge = cycle 0.
  - Store: lanes are issued in cycles 1..`lanes`, and `resp_valid` rises in cycle `lanes+1`.
  - Load: lanes are issued in cycles 1..`lanes`, LDRAIN is cycle `lanes+1`, and `resp_valid` rises in cycle `lanes+2`.
- **Handshake.**
  - `req_ready` is 0 in every state except IDLE.
  - No request is accepted in the cycle a response completes; the next accept is the cycle after, so throughput is 1 request per `lanes+2` (store) or `lanes+3` (load) cycles minimum.
- **Back-pressure.** `resp_ready` held low keeps RESP indefinitely, with all `mem_*` outputs at their idle values.
- **All-zero mask.** The request still runs its full cycle count. No writes occur; a load returns all zeros.

## Structure
- Shared package `simd_mem_pkg` holds:
  - the state enum `lsu_state_t`;
  - default constants `LANES = 4`, `DATA_W = 32`, `LSU_ADDR_STEP = 16`.
- No sub-module. One FSM with a lane counter of `$clog2(lanes+1)` bits.

## Test plan
- **Store then load.** Store `base=0x40`, mask `1111`, data {0x11111111, 0x22222222, 0x33333333, 0x44444444}, then load `base=0x40`.
  - Writes appear at addresses 0x40, 0x50, 0x60, 0x70.
  - The load returns the same four words; `resp_valid` rises in cycle 5 for the store and cycle 6 for the load.
- **Masked store.** Store mask `0101` over a region preloaded with 0xAAAAAAAA.
  - `mem_write_enable` is high only for lanes 0 and 2.
  - A readback gives {d0, 0xAAAAAAAA, d2, 0xAAAAAAAA}.
- **Masked load.** Load mask `0010` → `resp_rdata = {0, word1, 0, 0}`.
- **Back-pressure.** Hold `resp_ready = 0` for 10 cycles.
  - `resp_rdata` is stable, `req_ready = 0`, and `mem_write_enable = 0` throughout.
  - The response is accepted on the first high cycle, and `req_ready` returns the next cycle.
- **Reset mid-store.** Assert `rst` during lane 1 of a store.
  - Lanes 2–3 are never written.
  - All outputs reach their reset values on the next edge.
- **Address wrap.** Base `0xFFFFFFF0` with step 16 → lane 1 address is `0x00000000`.
